// File: rtl/indexed_address_unit.sv
// indexed_address_unit
//   Effective-address generator for the 65C02 indexed and indirect-indexed
//   addressing modes. It samples the X/Y index values at start, gathers the
//   operand and pointer bytes from the data bus, adds the index, and inserts
//   the page-crossing fix-up cycle used by the sequencer for its dummy access.
//
//   Configuration macro: AGU_INDIRECT_EN
//     defined   -> modes 4 (zp,X) and 5 (zp),Y with PTR_LO/PTR_HI states
//     undefined -> only modes 0-3 are legal; ptr_req/ptr_addr are tied to 0
//
//   Ports
//     fclk        in   core clock, rising edge
//     reset       in   synchronous active-high reset
//     start       in   begin a calculation (IDLE only)
//     mode[2:0]   in   0 zp,X 1 zp,Y 2 abs,X 3 abs,Y 4 (zp,X) 5 (zp),Y
//     is_write    in   store/RMW instruction, forces the fix-up cycle
//     db_in[7:0]  in   operand / pointer byte
//     db_valid    in   db_in holds the byte the current wait state expects
//     x_in[7:0]   in   X index value
//     y_in[7:0]   in   Y index value
//     ptr_req     out  pointer-byte fetch requested from ptr_addr
//     ptr_addr    out  zero-page pointer fetch address
//     ea          out  effective address
//     ea_valid    out  one-cycle pulse, ea/page_cross final
//     page_cross  out  index add carried into the high byte
//     fixup       out  high during the FIXUP cycle
//     busy        out  high in every state except IDLE
module indexed_address_unit (
  input  logic        fclk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic        is_write,
  input  logic [7:0]  db_in,
  input  logic        db_valid,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  output logic        ptr_req,
  output logic [15:0] ptr_addr,
  output logic [15:0] ea,
  output logic        ea_valid,
  output logic        page_cross,
  output logic        fixup,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP_LO = 3'd1,
    S_OP_HI = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
`ifdef AGU_INDIRECT_EN
    ,
    S_PTR_LO = 3'd5,
    S_PTR_HI = 3'd6
`endif
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  mode_q;
  logic        wr_q;
  logic [7:0]  idx_q;
  logic [7:0]  lo_q, lo_nx;
  logic [15:0] ea_nx;
  logic        pc_nx;
  logic        mode_legal;
  logic        accept;
  logic [7:0]  zp_sum;
  logic [8:0]  idx_sum;
  logic [7:0]  hi_sum;

`ifdef AGU_INDIRECT_EN
  logic [7:0]  p_q, p_nx;
  logic [7:0]  p_plus1;
  logic        ptr_req_nx;
  logic [15:0] ptr_addr_nx;
  assign mode_legal = (mode <= 3'd5);
  assign p_plus1    = p_q + 8'd1;   // wraps inside the zero page
`else
  assign mode_legal = (mode <= 3'd3);
  assign ptr_req    = 1'b0;
  assign ptr_addr   = 16'h0000;
`endif

  assign accept  = (state == S_IDLE) && start && mode_legal;
  assign zp_sum  = db_in + idx_q;
  // 9-bit low-byte add; bit 8 is the page-crossing carry into the high byte
  assign idx_sum = {1'b0, lo_q} + {1'b0, idx_q};
  assign hi_sum  = db_in + {7'd0, idx_sum[8]};

  // State and output registers
  always_ff @(posedge fclk) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= 3'd0;
      wr_q       <= 1'b0;
      idx_q      <= 8'h00;
      lo_q       <= 8'h00;
      ea         <= 16'h0000;
      page_cross <= 1'b0;
      ea_valid   <= 1'b0;
      fixup      <= 1'b0;
      busy       <= 1'b0;
`ifdef AGU_INDIRECT_EN
      p_q        <= 8'h00;
      ptr_req    <= 1'b0;
      ptr_addr   <= 16'h0000;
`endif
    end else begin
      state      <= state_nx;
      lo_q       <= lo_nx;
      ea         <= ea_nx;
      page_cross <= pc_nx;
      ea_valid   <= (state_nx == S_DONE);
      fixup      <= (state_nx == S_FIXUP);
      busy       <= (state_nx != S_IDLE);
`ifdef AGU_INDIRECT_EN
      p_q        <= p_nx;
      ptr_req    <= ptr_req_nx;
      ptr_addr   <= ptr_addr_nx;
`endif
      // Index is frozen here so later X/Y updates cannot disturb the add
      if (accept) begin
        mode_q <= mode;
        wr_q   <= is_write;
        idx_q  <= mode[0] ? y_in : x_in;
      end else begin
        mode_q <= mode_q;
        wr_q   <= wr_q;
        idx_q  <= idx_q;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start && mode_legal) state_nx = S_OP_LO;
        else                     state_nx = S_IDLE;
      end
      S_OP_LO: begin
        if (db_valid) begin
          case (mode_q)
            3'd0, 3'd1: state_nx = S_DONE;
            3'd2, 3'd3: state_nx = S_OP_HI;
`ifdef AGU_INDIRECT_EN
            3'd4, 3'd5: state_nx = S_PTR_LO;
`endif
            default:    state_nx = S_DONE;
          endcase
        end else begin
          state_nx = S_OP_LO;
        end
      end
      S_OP_HI: begin
        if (db_valid) state_nx = (idx_sum[8] || wr_q) ? S_FIXUP : S_DONE;
        else          state_nx = S_OP_HI;
      end
`ifdef AGU_INDIRECT_EN
      S_PTR_LO: begin
        if (db_valid) state_nx = S_PTR_HI;
        else          state_nx = S_PTR_LO;
      end
      S_PTR_HI: begin
        if (!db_valid)            state_nx = S_PTR_HI;
        else if (mode_q == 3'd4)  state_nx = S_DONE;
        else                      state_nx = (idx_sum[8] || wr_q) ? S_FIXUP : S_DONE;
      end
`endif
      S_FIXUP: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    ea_nx = ea;
    pc_nx = page_cross;
    lo_nx = lo_q;
`ifdef AGU_INDIRECT_EN
    p_nx  = p_q;
`endif
    case (state)
      S_IDLE: begin
        // ea/page_cross are held until a new calculation is accepted
        if (start && mode_legal) begin
          ea_nx = 16'h0000;
          pc_nx = 1'b0;
        end else begin
          ea_nx = ea;
        end
      end
      S_OP_LO: begin
        if (db_valid) begin
          case (mode_q)
            3'd0, 3'd1: ea_nx = {8'h00, zp_sum};   // zero-page wrap, no carry
            3'd2, 3'd3: lo_nx = db_in;
`ifdef AGU_INDIRECT_EN
            3'd4:       p_nx  = zp_sum;
            3'd5:       p_nx  = db_in;
`endif
            default:    lo_nx = lo_q;
          endcase
        end else begin
          lo_nx = lo_q;
        end
      end
      S_OP_HI: begin
        if (db_valid) begin
          ea_nx = {hi_sum, idx_sum[7:0]};
          pc_nx = idx_sum[8];
        end else begin
          ea_nx = ea;
        end
      end
`ifdef AGU_INDIRECT_EN
      S_PTR_LO: begin
        if (db_valid) lo_nx = db_in;
        else          lo_nx = lo_q;
      end
      S_PTR_HI: begin
        if (!db_valid) begin
          ea_nx = ea;
        end else if (mode_q == 3'd4) begin
          ea_nx = {db_in, lo_q};
        end else begin
          ea_nx = {hi_sum, idx_sum[7:0]};
          pc_nx = idx_sum[8];
        end
      end
`endif
      default: ea_nx = ea;
    endcase
  end

`ifdef AGU_INDIRECT_EN
  // Pointer fetch request, registered against the state being entered
  always_comb begin
    ptr_req_nx  = 1'b0;
    ptr_addr_nx = 16'h0000;
    if (state_nx == S_PTR_LO) begin
      ptr_req_nx  = 1'b1;
      ptr_addr_nx = {8'h00, p_nx};
    end else if (state_nx == S_PTR_HI) begin
      ptr_req_nx  = 1'b1;
      ptr_addr_nx = {8'h00, p_plus1};
    end else begin
      ptr_req_nx  = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_indexed_address_unit.sv
module tb_indexed_address_unit;

  logic        fclk = 1'b0;
  logic        reset, start, is_write, db_valid;
  logic [2:0]  mode;
  logic [7:0]  db_in, x_in, y_in;
  logic        ptr_req, ea_valid, page_cross, fixup, busy;
  logic [15:0] ptr_addr, ea;

  int checks = 0;
  int errors = 0;

  indexed_address_unit dut (
    .fclk(fclk), .reset(reset), .start(start), .mode(mode), .is_write(is_write),
    .db_in(db_in), .db_valid(db_valid), .x_in(x_in), .y_in(y_in),
    .ptr_req(ptr_req), .ptr_addr(ptr_addr), .ea(ea), .ea_valid(ea_valid),
    .page_cross(page_cross), .fixup(fixup), .busy(busy)
  );

  always #5 fclk = ~fclk;

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic       wr;
    logic [7:0] x, y;
    logic [7:0] b0, b1, b2;
    int         stall;
    bit         poke;      // hold start high (other mode) while busy
    bit         ind;       // check pointer fetch addresses
    logic [15:0] p0, p1;
    logic [15:0] exp_ea;
    logic       exp_pc;
    int         exp_fix;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] m, input logic wr,
                              input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int stall, input bit poke,
                              input logic [15:0] e, input logic pc, input int fx, input int lat);
    vec_t v;
    v.name = name; v.mode = m; v.wr = wr; v.x = x; v.y = y;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.stall = stall; v.poke = poke;
    v.ind = 1'b0; v.p0 = 16'h0000; v.p1 = 16'h0000;
    v.exp_ea = e; v.exp_pc = pc; v.exp_fix = fx; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ea"}, ea, 16'h0000);
    chk({tag, "_ea_valid"}, {15'd0, ea_valid}, 16'h0000);
    chk({tag, "_page_cross"}, {15'd0, page_cross}, 16'h0000);
    chk({tag, "_fixup"}, {15'd0, fixup}, 16'h0000);
    chk({tag, "_busy"}, {15'd0, busy}, 16'h0000);
    chk({tag, "_ptr_req"}, {15'd0, ptr_req}, 16'h0000);
    chk({tag, "_ptr_addr"}, ptr_addr, 16'h0000);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, k, fix_cnt, stall_left;
    logic [7:0] b;
    @(negedge fclk);
    start = 1'b1; mode = v.mode; is_write = v.wr; x_in = v.x; y_in = v.y;
    db_valid = 1'b1; db_in = 8'h00;
    @(posedge fclk); #1;
    cyc = 1; k = 0; fix_cnt = 0; stall_left = v.stall;
    chk({v.name, "_busy_rise"}, {15'd0, busy}, 16'h0001);
    while (!ea_valid && cyc < 20) begin
      @(negedge fclk);
      // scramble the index inputs: the in-flight calculation must not see them
      x_in = 8'hC3; y_in = 8'h3C;
      if (v.poke) begin start = 1'b1; mode = 3'd0; end
      else        start = 1'b0;
      if (stall_left > 0) begin
        db_valid = 1'b0; stall_left--;
      end else begin
        case (k)
          0:       b = v.b0;
          1:       b = v.b1;
          default: b = v.b2;
        endcase
        db_valid = 1'b1; db_in = b;
        if (k < 3) k++;
      end
      @(posedge fclk); #1;
      cyc++;
      if (fixup) fix_cnt++;
      if (v.ind && cyc == 2) chk({v.name, "_ptr_lo"}, ptr_req ? ptr_addr : 16'hDEAD, v.p0);
      if (v.ind && cyc == 3) chk({v.name, "_ptr_hi"}, ptr_req ? ptr_addr : 16'hDEAD, v.p1);
    end
    chk({v.name, "_ea_valid"}, {15'd0, ea_valid}, 16'h0001);
    chk({v.name, "_latency"}, cyc[15:0], v.exp_lat[15:0]);
    chk({v.name, "_ea"}, ea, v.exp_ea);
    chk({v.name, "_page_cross"}, {15'd0, page_cross}, {15'd0, v.exp_pc});
    chk({v.name, "_fixup_cycles"}, fix_cnt[15:0], v.exp_fix[15:0]);
    // start is still high here when poking: it lands in DONE and must be ignored
    @(negedge fclk); start = 1'b0; db_valid = 1'b0;
    @(posedge fclk); #1;
    chk({v.name, "_pulse_end"}, {15'd0, ea_valid}, 16'h0000);
    chk({v.name, "_busy_fall"}, {15'd0, busy}, 16'h0000);
    chk({v.name, "_ea_hold"}, ea, v.exp_ea);
    @(negedge fclk);
    @(posedge fclk); #1;
    chk({v.name, "_no_restart"}, {15'd0, busy}, 16'h0000);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; mode = 3'd0; is_write = 1'b0;
    db_in = 8'h00; db_valid = 1'b0; x_in = 8'h00; y_in = 8'h00;

    vecs.push_back(mk("abs_y",       3'd3, 1'b0, 8'h00, 8'h10, 8'h34, 8'h12, 8'h00, 0, 1'b0, 16'h1244, 1'b0, 0, 3));
    vecs.push_back(mk("abs_x_cross", 3'd2, 1'b0, 8'h20, 8'h00, 8'hF0, 8'h12, 8'h00, 0, 1'b0, 16'h1310, 1'b1, 1, 4));
    vecs.push_back(mk("abs_x_write", 3'd2, 1'b1, 8'h01, 8'h00, 8'hF0, 8'h12, 8'h00, 0, 1'b0, 16'h12F1, 1'b0, 1, 4));
    vecs.push_back(mk("zp_x_wrap",   3'd0, 1'b0, 8'h20, 8'h00, 8'hF0, 8'h00, 8'h00, 0, 1'b0, 16'h0010, 1'b0, 0, 2));
    vecs.push_back(mk("abs_hi_wrap", 3'd2, 1'b0, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1'b0, 16'h0000, 1'b1, 1, 4));
    vecs.push_back(mk("zp_y_stall",  3'd1, 1'b0, 8'h00, 8'h7F, 8'h80, 8'h00, 8'h00, 3, 1'b0, 16'h00FF, 1'b0, 0, 5));
    vecs.push_back(mk("abs_y_poke",  3'd3, 1'b0, 8'h00, 8'hFF, 8'h00, 8'h40, 8'h00, 0, 1'b1, 16'h40FF, 1'b0, 0, 3));
`ifdef AGU_INDIRECT_EN
    v = mk("ind_y", 3'd5, 1'b0, 8'h00, 8'h90, 8'hFF, 8'h80, 8'h20, 0, 1'b0, 16'h2110, 1'b1, 1, 5);
    v.ind = 1'b1; v.p0 = 16'h00FF; v.p1 = 16'h0000;
    vecs.push_back(v);
    v = mk("ind_x", 3'd4, 1'b1, 8'h05, 8'h00, 8'h10, 8'h34, 8'h12, 0, 1'b0, 16'h1234, 1'b0, 0, 4);
    v.ind = 1'b1; v.p0 = 16'h0015; v.p1 = 16'h0016;
    vecs.push_back(v);
`endif

    // reset state
    repeat (2) @(posedge fclk);
    #1;
    check_idle_zero("reset");
    @(negedge fclk); reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // illegal modes: start is ignored
    @(negedge fclk); start = 1'b1; mode = 3'd6; db_valid = 1'b1;
    @(posedge fclk); #1;
    chk("illegal6_busy", {15'd0, busy}, 16'h0000);
`ifndef AGU_INDIRECT_EN
    @(negedge fclk); mode = 3'd5;
    @(posedge fclk); #1;
    chk("mode5_disabled_busy", {15'd0, busy}, 16'h0000);
`endif
    @(negedge fclk); start = 1'b0;

    // reset mid-operation
    @(negedge fclk);
`ifdef AGU_INDIRECT_EN
    start = 1'b1; mode = 3'd5; y_in = 8'h90; db_valid = 1'b1;
    @(negedge fclk); start = 1'b0; db_in = 8'hFF;
    @(negedge fclk); db_in = 8'h80;
    @(posedge fclk); #1;
    chk("pre_reset_ptr_req", {15'd0, ptr_req}, 16'h0001);
`else
    start = 1'b1; mode = 3'd2; x_in = 8'h20; db_valid = 1'b1;
    @(negedge fclk); start = 1'b0; db_in = 8'hF0;
    @(posedge fclk); #1;
`endif
    chk("pre_reset_busy", {15'd0, busy}, 16'h0001);
    @(negedge fclk); reset = 1'b1; start = 1'b1; mode = 3'd0;
    @(posedge fclk); #1;
    check_idle_zero("mid_reset");
    @(negedge fclk); reset = 1'b0; start = 1'b0;

    run_vec(mk("zp_y_after_rst", 3'd1, 1'b0, 8'h00, 8'h03, 8'h05, 8'h00, 8'h00, 0, 1'b0, 16'h0008, 1'b0, 0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/indexed_address_unit.md
# indexed_address_unit

Effective-address generator for the 65C02 core's indexed and indirect-indexed addressing modes. Sits directly downstream of the X and Y index registers: samples their `address_out` values, gathers operand and pointer bytes from the data bus, and produces a 16-bit effective address. It also inserts the page-crossing fix-up cycle that the sequencer uses for the dummy bus access.

## Interface
Parameters: none.

Clock and reset are fixed: one clock, `fclk`; `reset` is synchronous and active-high.

- `fclk` in 1: core clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin an address calculation; accepted only in IDLE.
- `mode` in 3: addressing mode, sampled with `start`.
  - 0 zp,X; 1 zp,Y; 2 abs,X; 3 abs,Y; 4 (zp,X); 5 (zp),Y; 6–7 illegal.
- `is_write` in 1: the instruction is a store/RMW; sampled with `start`.
- `db_in` in 8: operand or pointer byte.
- `db_valid` in 1: `db_in` holds the byte the current wait state expects.
- `x_in` in 8: X index value; sampled with `start`.
- `y_in` in 8: Y index value, taken from the index register's `address_out`; sampled with `start`.
- `ptr_req` out 1: a pointer-byte fetch from `ptr_addr` is requested.
- `ptr_addr` out 16: zero-page pointer fetch address.
- `ea` out 16: effective address.
- `ea_valid` out 1: one-cycle pulse; `ea` and `page_cross` are final.
- `page_cross` out 1: the index add carried into the high byte.
- `fixup` out 1: high during the FIXUP cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIXUP, DONE.
- Every wait state holds until `db_valid` is high. `db_valid` is ignored in all other states.
- IDLE:
  - With `start` and a legal mode: latch `mode`, `is_write`, and the index (X for modes 0/2/4, Y for 1/3/5), then go to OP_LO.
  - Illegal mode: `start` is ignored and the block stays in IDLE.
- OP_LO: capture byte `b`.
  - Modes 0/1: `ea` = {8'h00, (b+idx)[7:0]} (zero-page wrap, no carry), then DONE.
  - Modes 2/3: go to OP_HI.
  - Mode 4: `p` = (b+X)[7:0], then PTR_LO.
  - Mode 5: `p` = b, then PTR_LO.
- OP_HI: capture `hi`. Compute the 9-bit sum `s` = lo + idx; `ea` = {hi + s[8], s[7:0]}; `page_cross` = s[8].
- PTR_LO: `ptr_req` = 1, `ptr_addr` = {8'h00, p}; capture `lo`.
- PTR_HI: `ptr_req` = 1, `ptr_addr` = {8'h00, (p+1)[7:0]}; capture `hi`. Wraps within the zero page, so p = FF fetches from 0x00FF and 0x0000.
  - Mode 4: `ea` = {hi, lo}, then DONE.
  - Mode 5: apply the OP_HI sum rule with Y.
- After the index add (modes 2/3/5): go to FIXUP if `page_cross` or `is_write`, else DONE.
- FIXUP: `fixup` = 1 for exactly one cycle, then DONE.
- DONE: `ea_valid` = 1 for one cycle, then IDLE.
- `ea` and `page_cross` hold their values until the next accepted `start`.
- `page_cross` is always 0 for modes 0, 1 and 4.
- The effective-address high byte wraps: FF + carry = 00, so `ea` is 16-bit modulo.
- Index values are frozen at `start`. A later `y_increment`/`y_decrement` on the Y register does not affect an in-flight calculation.

## Timing
- Reset value of every output: 0 (`ea` = 16'h0000; `ea_valid`, `page_cross`, `fixup`, `busy`, `ptr_req` = 0; `ptr_addr` = 16'h0000).
- State returns to IDLE on reset.
- `reset` mid-operation: the next cycle is IDLE with all outputs 0; captured bytes are discarded. `reset` has priority over `start`.
- `busy` rises the cycle after `start` is accepted and falls the cycle after DONE.
- Minimum latency, from the `start` edge to `ea_valid`, with `db_valid` always high:
  - zp: 2 cycles.
  - abs without fix-up: 3 cycles; abs with fix-up: 4.
  - (zp,X): 4 cycles.
  - (zp),Y: 4 cycles, or 5 with fix-up.
- Each cycle `db_valid` is low in a wait state adds one cycle.
- `start` while `busy` is ignored and not queued. `start` during DONE is ignored.
- `start` in the cycle after DONE, once back in IDLE, is accepted: back-to-back operation.

## Configuration
- `AGU_INDIRECT_EN` defined: modes 4 and 5, together with the PTR_LO/PTR_HI states and `ptr_req`/`ptr_addr` logic, are compiled in.
- `AGU_INDIRECT_EN` undefined:
  - Modes 4/5 are illegal and `start` with them is ignored.
  - `ptr_req` is tied 0 and `ptr_addr` is tied 16'h0000.
  - PTR states are absent.

## Test plan
- abs,Y: base bytes 34,12; Y=10 → `ea`=1244, `page_cross`=0, no `fixup`, `ea_valid` 3 cycles after `start`.
- abs,X page cross: bytes F0,12; X=20 → `ea`=1310, `page_cross`=1, `fixup` one cycle, `ea_valid` at cycle 4. Same inputs with `is_write`=1 and X=01: `ea`=12F1, `page_cross`=0, but `fixup` still asserted.
- zp,X wrap: byte F0; X=20 → `ea`=0010, `page_cross`=0, latency 2. abs high-byte wrap: bytes FF,FF; X=01 → `ea`=0000, `page_cross`=1.
- (zp),Y: zp=FF; mem[00FF]=80, mem[0000]=20; Y=90 → `ptr_addr` 00FF then 0000, `ea`=2110, `page_cross`=1, latency 5. With `AGU_INDIRECT_EN` undefined, `start` with mode 5 leaves `busy` at 0.
- Stalls and sampling: hold `db_valid` low 3 cycles in OP_LO → latency +3. Changing `y_in` after `start` does not alter `ea`. `start` while `busy` is ignored.
- `reset` asserted in PTR_HI → next cycle IDLE, all outputs 0. A subsequent zp,Y with byte 05 and Y=03 gives `ea`=0008.
